// File: rtl/sum_collect_if.sv
// Result hand-off bus: capture side (add_end/sum) and show-ahead read side.
interface sum_collect_if;
  logic       add_end;
  logic [7:0] sum;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] rd_seq;

  modport master (
    output add_end, sum, rd_ready,
    input  rd_valid, rd_data, rd_seq
  );

  modport slave (
    input  add_end, sum, rd_ready,
    output rd_valid, rd_data, rd_seq
  );
endinterface

// File: rtl/sum_collect.sv
// Collects accumulator results into a tagged show-ahead FIFO, and tracks the
// running maximum and a sticky drop flag.
module sum_collect #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          clr,
  sum_collect_if.slave  bus,
  output logic [AW:0]   fifo_cnt,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    max_sum
);

  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    seq;
  logic          vld;
  logic          pop;
  logic          push;
  logic [11:0]   head;

  assign vld  = (fifo_cnt != '0);
  assign full = (fifo_cnt == (AW+1)'(DEPTH));
  assign pop  = vld && bus.rd_ready;
  // A full FIFO still accepts a result when the head leaves at the same edge.
  assign push = bus.add_end && (!full || pop);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      max_sum  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      max_sum  <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        seq     <= seq + 4'd1;
        max_sum <= max_u8(bus.sum, max_sum);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - (AW+1)'(1);
      if (bus.add_end && !push)
        overflow <= 1'b1;
    end
  end

  // Storage is data only; sum must be taken in the strobe cycle itself.
  always_ff @(posedge sys_clk) begin
    if (!clr && push)
      mem[wr_ptr] <= {seq, bus.sum};
  end

  assign head         = vld ? mem[rd_ptr] : 12'h000;
  assign bus.rd_valid = vld;
  assign bus.rd_data  = head[7:0];
  assign bus.rd_seq   = head[11:8];

endmodule

// File: tb/tb_sum_collect.sv
// Scoreboard bench for sum_collect: model queue tracks entries, tags, max and overflow.
module tb_sum_collect;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          sys_clk;
  logic          sys_rst;
  logic          clr;
  logic [AW:0]   fifo_cnt;
  logic          full;
  logic          overflow;
  logic [7:0]    max_sum;

  sum_collect_if bif ();

  sum_collect #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clr      (clr),
    .bus      (bif),
    .fifo_cnt (fifo_cnt),
    .full     (full),
    .overflow (overflow),
    .max_sum  (max_sum)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  logic [11:0] sbq [$];
  logic [3:0]  m_seq = 4'd0;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_max = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    m_seq = 4'd0;
    m_ovf = 1'b0;
    m_max = 8'd0;
  endtask

  // Called just after a rising edge: drives one cycle of stimulus, checks the
  // head against the model, advances the model and checks state after the edge.
  task automatic cycle(input logic a, input logic [7:0] s, input logic r, input logic c);
    logic pop_m;
    logic push_m;
    logic [11:0] h;
    bif.add_end  = a;
    bif.sum      = s;
    bif.rd_ready = r;
    clr          = c;
    #1;
    chk("rd_valid", 32'(bif.rd_valid), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      h = sbq[0];
      chk("head_data", 32'(bif.rd_data), 32'(h[7:0]));
      chk("head_seq", 32'(bif.rd_seq), 32'(h[11:8]));
    end else begin
      chk("empty_data", 32'(bif.rd_data), 32'h0);
      chk("empty_seq", 32'(bif.rd_seq), 32'h0);
    end
    pop_m  = (sbq.size() != 0) && r && !c;
    push_m = a && !c && (sbq.size() < DEPTH || pop_m);
    if (c) begin
      model_reset();
    end else begin
      if (pop_m) h = sbq.pop_front();
      if (push_m) begin
        sbq.push_back({m_seq, s});
        m_seq = m_seq + 4'd1;
        if (s > m_max) m_max = s;
      end
      if (a && !push_m) m_ovf = 1'b1;
    end
    @(posedge sys_clk);
    #1;
    chk("fifo_cnt", 32'(fifo_cnt), 32'(sbq.size()));
    chk("full", 32'(full), 32'(sbq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("max_sum", 32'(max_sum), 32'(m_max));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst      = 1'b0;
    clr          = 1'b0;
    bif.add_end  = 1'b0;
    bif.sum      = 8'd0;
    bif.rd_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bif.rd_valid), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_cnt", 32'(fifo_cnt), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_max", 32'(max_sum), 32'h0);
    chk("rst_data", 32'(bif.rd_data), 32'h0);
    chk("rst_seq", 32'(bif.rd_seq), 32'h0);
    #8 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;

    // single result
    cycle(1'b1, 8'h2A, 1'b0, 1'b0);
    chk("single_valid", 32'(bif.rd_valid), 32'h1);
    chk("single_data", 32'(bif.rd_data), 32'h2A);
    chk("single_seq", 32'(bif.rd_seq), 32'h0);
    chk("single_max", 32'(max_sum), 32'h2A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_drained", 32'(bif.rd_valid), 32'h0);

    // fill and overflow
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_ovf", 32'(overflow), 32'h0);
    cycle(1'b1, 8'd9, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_cnt", 32'(fifo_cnt), 32'h8);
    chk("ovf_max", 32'(max_sum), 32'h8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous write and pop while full
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b1, 1'b0);
    chk("wp_cnt", 32'(fifo_cnt), 32'h8);
    chk("wp_ovf", 32'(overflow), 32'h0);
    chk("wp_max", 32'(max_sum), 32'hF0);
    chk("wp_tail_seq", 32'(sbq[7][11:8]), 32'h8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // single held entry: write and pop together
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b1, 1'b0);
    chk("one_wp_cnt", 32'(fifo_cnt), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // sequence wrap, popped immediately
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (i == 16) chk("wrap_seq", 32'(bif.rd_seq), 32'h0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // backpressure hold, plus empty add_end with rd_ready
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("empty_wr_cnt", 32'(fifo_cnt), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("hold_data", 32'(bif.rd_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // clr priority
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_clr_cnt", 32'(fifo_cnt), 32'h3);
    chk("pre_clr_ovf", 32'(overflow), 32'h1);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    chk("clr_cnt", 32'(fifo_cnt), 32'h0);
    chk("clr_valid", 32'(bif.rd_valid), 32'h0);
    chk("clr_ovf", 32'(overflow), 32'h0);
    chk("clr_max", 32'(max_sum), 32'h0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    chk("clr_next_seq", 32'(bif.rd_seq), 32'h0);

    // async reset mid-drain
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_cnt", 32'(fifo_cnt), 32'h4);
    bif.add_end  = 1'b0;
    bif.rd_ready = 1'b0;
    #2 sys_rst = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(bif.rd_valid), 32'h0);
    chk("arst_cnt", 32'(fifo_cnt), 32'h0);
    chk("arst_data", 32'(bif.rd_data), 32'h0);
    chk("arst_max", 32'(max_sum), 32'h0);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    chk("post_rst_data", 32'(bif.rd_data), 32'h11);
    chk("post_rst_seq", 32'(bif.rd_seq), 32'h0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sum_collect.md
Name: sum_collect

Overview:
- Downstream stage of the single-pass accumulator.
- Captures each final 8-bit sum on the accumulator's one-cycle add_end strobe and tags it with a 4-bit sequence number.
- Buffers results in a show-ahead FIFO and hands them out over a valid/ready interface.
- Also tracks the running maximum result and a sticky overflow flag for results dropped while full.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- AW, 3, address width; must equal log2(DEPTH).

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous reset, active-low.
- add_end  in  1  one-cycle strobe: sum is final this cycle.
- sum  in  8  accumulator result; sampled only when add_end=1.
- clr  in  1  synchronous clear of FIFO, max, seq and overflow.
- rd_ready  in  1  consumer accepts the head entry this cycle.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  8  head entry sum value.
- rd_seq  out  4  head entry sequence tag.
- fifo_cnt  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  fifo_cnt==DEPTH.
- overflow  out  1  sticky: at least one result was dropped.
- max_sum  out  8  largest accepted sum since reset or clr (unsigned).

Behaviour:
- Reset (sys_rst=0, async):
  - Pointers, fifo_cnt, seq counter, overflow and max_sum all go to 0.
  - rd_valid=0, full=0.
  - rd_data and rd_seq read as 0 while empty: the output mux is forced to 0 when the FIFO is empty.
- Write:
  - A write occurs at an edge where add_end=1 and (fifo_cnt<DEPTH, or a pop also occurs at the same edge).
  - The entry stored is {seq, sum}; then seq increments, wrapping 15->0.
  - sum is sampled in the add_end cycle itself, because the upstream stage clears sum on the following edge.
- Pop:
  - A pop occurs at an edge where rd_valid=1 and rd_ready=1.
  - The read pointer advances, wrapping DEPTH-1->0.
  - rd_ready while empty has no effect.
- Show-ahead timing:
  - rd_data and rd_seq are combinational from the head entry.
  - A write into an empty FIFO at edge k makes rd_valid=1 in cycle k+1; this is a 1-cycle latency.
  - rd_data and rd_seq must not change while rd_valid=1 and rd_ready=0.
- fifo_cnt:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop, including when full and when exactly one entry is held.
- Full with no pop:
  - add_end=1 drops the result.
  - overflow is set to 1 and stays 1 until clr or reset.
  - seq does not increment and max_sum is not updated.
- Empty with add_end and rd_ready together: a write occurs and no pop occurs, because rd_valid was 0.
- max_sum:
  - On each write, max_sum <= (sum > max_sum) ? sum : max_sum.
  - The new value is visible the cycle after the write edge.
- clr:
  - Highest synchronous priority.
  - Pointers, fifo_cnt, seq, overflow and max_sum go to 0.
  - A simultaneous add_end or pop that cycle is discarded.
- Async reset mid-operation: all state is cleared immediately; stored entries are lost and are not required to be zeroed.
- No state machine beyond the FIFO pointers and counters; all arithmetic is unsigned with natural wrap.

Test Plan:
- Single result: empty FIFO, add_end with sum=0x2A, rd_ready=0.
  - Next cycle: rd_valid=1, rd_data=0x2A, rd_seq=0, fifo_cnt=1, max_sum=0x2A.
  - Raise rd_ready for one cycle: rd_valid=0, fifo_cnt=0.
- Fill and overflow: 9 add_end strobes with sums 1..9, rd_ready=0.
  - After 8 strobes: full=1, fifo_cnt=8, overflow=0.
  - 9th strobe: overflow=1, fifo_cnt=8, max_sum=8.
  - Drain: rd_data 1..8 in order, rd_seq 0..7.
- Simultaneous write and pop: FIFO full; add_end with sum=0xF0 and rd_ready=1 in the same cycle.
  - fifo_cnt stays 8, overflow stays 0.
  - The entry popped is the old head; 0xF0 becomes the tail with seq=8; max_sum=0xF0.
- Seq wrap: 17 captures, each popped immediately.
  - Tags observed: 0..15 then 0.
  - Backpressure hold (rd_ready=0 for 3 cycles): rd_data and rd_seq stable throughout.
- clr priority: 3 entries stored, overflow=1; assert clr together with add_end (sum=0x55) and rd_ready.
  - Next cycle: fifo_cnt=0, rd_valid=0, overflow=0, max_sum=0.
  - The next capture has rd_seq=0.
- Async reset mid-drain: drive sys_rst=0 between clock edges while 4 entries are held.
  - Outputs clear immediately (rd_valid=0, fifo_cnt=0, rd_data=0).
  - After release, a new capture of 0x11 appears with rd_seq=0.
